// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the registered bitwise logic unit.
// Op codes, state encoding and sizes used by the unit, its datapath and its interface.
package logic_unit_pkg;

   localparam int OP_W    = 3;
   localparam int NUM_OPS = 8;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NOT  = 3'd2,
      OP_XOR  = 3'd3,
      OP_NAND = 3'd4,
      OP_NOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_PASS = 3'd7
   } op_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

endpackage

// File: rtl/logic_unit_reg_if.sv
// Operand/result handshake bundle for logic_unit_reg.
// The source drives operands and out_ready; the unit drives in_ready and the result register.
interface logic_unit_reg_if #(
   parameter int WIDTH = 4
) ();
   import logic_unit_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [OP_W-1:0]  op;
   logic             mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic [OP_W-1:0]  out_op;
   logic             zero;
   logic             out_last;

   modport master (
      output in_valid, a, b, op, mode, out_ready,
      input  in_ready, out_valid, y, out_op, zero, out_last
   );

   modport slave (
      input  in_valid, a, b, op, mode, out_ready,
      output in_ready, out_valid, y, out_op, zero, out_last
   );

endinterface

// File: rtl/logic_unit_comb.sv
// Purely combinational bitwise operator: maps (a, b, op) to y.
// No carries or sign handling; every output bit depends only on the same input bits.
module logic_unit_comb
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (op_t'(op))
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NOT:  y = ~a;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XNOR: y = ~(a ^ b);
         OP_PASS: y = b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic_unit_reg.sv
// Registered bitwise logic unit with a single backpressured output register.
// Single mode applies one op per beat; sweep mode replays all eight ops on a latched operand pair.
module logic_unit_reg
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input logic           clk,
   input logic           rst,
   logic_unit_reg_if.slave bus
);

   state_t           state;
   logic [OP_W-1:0]  cnt;
   logic [WIDTH-1:0] a_lat;
   logic [WIDTH-1:0] b_lat;

   logic             out_valid_q;
   logic [WIDTH-1:0] y_q;
   logic [OP_W-1:0]  out_op_q;
   logic             zero_q;
   logic             out_last_q;

   logic             slot_free;
   logic             in_ready;
   logic             accept;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [OP_W-1:0]  sel_op;
   logic [WIDTH-1:0] comb_y;

   assign slot_free = !out_valid_q || bus.out_ready;
   assign in_ready  = (state == IDLE) && slot_free;
   assign accept    = bus.in_valid && in_ready;

   // One shared operator: live inputs in IDLE (op 0 when starting a sweep), latched pair plus counter in SWEEP.
   always_comb begin
      sel_a  = bus.a;
      sel_b  = bus.b;
      sel_op = bus.mode ? OP_W'(0) : bus.op;
      if (state == SWEEP) begin
         sel_a  = a_lat;
         sel_b  = b_lat;
         sel_op = cnt;
      end
   end

   logic_unit_comb #(.WIDTH(WIDTH)) u_comb (
      .a  (sel_a),
      .b  (sel_b),
      .op (sel_op),
      .y  (comb_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         a_lat       <= '0;
         b_lat       <= '0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         out_op_q    <= '0;
         zero_q      <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  out_valid_q <= 1'b1;
                  y_q         <= comb_y;
                  out_op_q    <= sel_op;
                  zero_q      <= (comb_y == '0);
                  if (bus.mode) begin
                     out_last_q <= 1'b0;
                     a_lat      <= bus.a;
                     b_lat      <= bus.b;
                     cnt        <= OP_W'(1);
                     state      <= SWEEP;
                  end else begin
                     out_last_q <= 1'b1;
                  end
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            SWEEP: begin
               // A stalled sink freezes the counter, so no sweep beat is skipped or repeated.
               if (slot_free) begin
                  out_valid_q <= 1'b1;
                  y_q         <= comb_y;
                  out_op_q    <= sel_op;
                  zero_q      <= (comb_y == '0);
                  out_last_q  <= (cnt == OP_W'(NUM_OPS - 1));
                  if (cnt == OP_W'(NUM_OPS - 1)) begin
                     cnt   <= '0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + OP_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.out_op    = out_op_q;
   assign bus.zero      = zero_q;
   assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_logic_unit_reg.sv
// Scoreboard bench for logic_unit_reg: stimulus pushes hand-computed beats, a monitor pops on each handshake.
// Covers reset, single ops, zero flag, sweep timing, backpressure and reset mid-sweep.
module tb_logic_unit_reg;

   typedef struct packed {
      logic [3:0] y;
      logic [2:0] op;
      logic       zero;
      logic       last;
   } exp_t;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;
   exp_t sb[$];

   // Truth table of every op for a=1100, b=1010, worked out by hand.
   logic [3:0] tab [8] = '{4'b1000, 4'b1110, 4'b0011, 4'b0110,
                           4'b0111, 4'b0001, 4'b1001, 4'b1010};

   logic_unit_reg_if #(.WIDTH(4)) bus ();

   logic_unit_reg #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: every handshake must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         tests_run++;
         if (sb.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_beat: y=%b op=%0d with empty scoreboard", bus.y, bus.out_op);
         end else begin
            e = sb.pop_front();
            if (bus.y !== e.y || bus.out_op !== e.op || bus.zero !== e.zero || bus.out_last !== e.last) begin
               tests_failed++;
               $display("[TB] FAIL beat: got y=%b op=%0d zero=%b last=%b, expected y=%b op=%0d zero=%b last=%b",
                        bus.y, bus.out_op, bus.zero, bus.out_last, e.y, e.op, e.zero, e.last);
            end
         end
      end
   end

   task automatic pushSweep();
      for (int k = 0; k < 8; k++)
         sb.push_back('{y: tab[k], op: 3'(k), zero: (tab[k] == 4'b0000), last: (k == 7)});
   endtask

   // Offer one beat, wait (bounded) for acceptance, and record its expected result(s).
   task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                                input logic mode, input logic [3:0] exp_y, output int waits);
      bit ok;
      ok = 0;
      waits = 0;
      bus.in_valid = 1'b1;
      bus.a = a;
      bus.b = b;
      bus.op = op;
      bus.mode = mode;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1;
            break;
         end
         waits++;
      end
      if (!ok) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL accept_timeout: in_ready=0, expected 1 within 50 cycles");
      end else if (mode) begin
         pushSweep();
      end else begin
         sb.push_back('{y: exp_y, op: op, zero: (exp_y == 4'b0000), last: 1'b1});
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      tests_run = 0;
      tests_failed = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.op = '0;
      bus.mode = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_y", 32'(bus.y), 32'd0);
      checkOutput("rst_out_op", 32'(bus.out_op), 32'd0);
      checkOutput("rst_zero", 32'(bus.zero), 32'd0);
      checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Single ops back-to-back: no wait cycles expected
      for (int k = 0; k < 8; k++) begin
         applyStimulus(4'b1100, 4'b1010, 3'(k), 1'b0, tab[k], w);
         checkOutput("single_in_ready", 32'(w), 32'd0);
      end
      idleCycles(3);

      // Zero flag
      applyStimulus(4'b0101, 4'b1010, 3'd0, 1'b0, 4'b0000, w);
      applyStimulus(4'b0101, 4'b1010, 3'd1, 1'b0, 4'b1111, w);
      idleCycles(3);
      checkOutput("zero_drained", 32'(sb.size()), 32'd0);

      // Sweep, with garbage inputs offered mid-sweep and a second sweep on the op 7 cycle
      applyStimulus(4'b1100, 4'b1010, 3'd5, 1'b1, 4'b0000, w);
      bus.in_valid = 1'b1;
      bus.a = 4'b0000;
      bus.b = 4'b1111;
      bus.op = 3'd2;
      bus.mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput($sformatf("sweep_in_ready_%0d", i), 32'(bus.in_ready), (i < 7) ? 32'd0 : 32'd1);
         if (i == 7) pushSweep();
         @(posedge clk);
         #1;
         if (i == 6) begin
            bus.a = 4'b1100;
            bus.b = 4'b1010;
            bus.op = 3'd4;
            bus.mode = 1'b1;
         end
         if (i == 7) bus.in_valid = 1'b0;
      end
      idleCycles(10);
      checkOutput("sweep_drained", 32'(sb.size()), 32'd0);

      // Backpressure on the op 3 beat
      applyStimulus(4'b1100, 4'b1010, 3'd0, 1'b1, 4'b0000, w);
      idleCycles(3);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("stall_y", 32'(bus.y), 32'b0110);
         checkOutput("stall_op", 32'(bus.out_op), 32'd3);
         checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
         @(posedge clk);
      end
      #1 bus.out_ready = 1'b1;
      idleCycles(10);
      checkOutput("stall_drained", 32'(sb.size()), 32'd0);

      // Reset while op 5 is presented
      applyStimulus(4'b1100, 4'b1010, 3'd0, 1'b1, 4'b0000, w);
      idleCycles(5);
      checkOutput("mid_rst_op_before", 32'(bus.out_op), 32'd5);
      rst = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("mid_rst_y", 32'(bus.y), 32'd0);
      checkOutput("mid_rst_last", 32'(bus.out_last), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("post_rst_valid", 32'(bus.out_valid), 32'd0);
         checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      end

      checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
